// File: rtl/udlx_pkg.sv
// udlx_pkg
//   Shared definitions for the udlx pipeline: the default widths used by the
//   pipeline stages and the state encoding of the memory-access FSM.
//   There are no ports; other files import udlx_pkg::*.
package udlx_pkg;

   localparam int UDLX_DATA_WIDTH     = 32;
   localparam int UDLX_REG_ADDR_WIDTH = 5;
   localparam int UDLX_ACK_TIMEOUT    = 16;

   // Memory-stage FSM: IDLE waits for a load/store, ACCESS holds the request
   // on the data-memory bus until ack or timeout.
   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } mem_state_t;

endpackage

// File: rtl/memory_pipe.sv
// memory_pipe
//   MEM/WB pipeline register of the udlx pipeline.
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     stall             1 = insert a bubble (reg_wr_en_q <= 0, other fields hold)
//     alu_data, reg_wr_en, reg_wr_addr, wb_mux_sel
//                       write-back fields from EX/MEM
//     load_en, load_data
//                       update strobe and value for the load-data field
//     mem_data_q, alu_data_q, reg_wr_en_q, reg_wr_addr_q, wb_mux_sel_q
//                       registered MEM/WB outputs
module memory_pipe
   import udlx_pkg::*;
#(
   parameter int DATA_WIDTH     = UDLX_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = UDLX_REG_ADDR_WIDTH
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      stall,
   input  logic [DATA_WIDTH-1:0]     alu_data,
   input  logic                      reg_wr_en,
   input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr,
   input  logic                      wb_mux_sel,
   input  logic                      load_en,
   input  logic [DATA_WIDTH-1:0]     load_data,
   output logic [DATA_WIDTH-1:0]     mem_data_q,
   output logic [DATA_WIDTH-1:0]     alu_data_q,
   output logic                      reg_wr_en_q,
   output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_q,
   output logic                      wb_mux_sel_q
);

   // MEM -> WB stage boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_data_q    <= '0;
         alu_data_q    <= '0;
         reg_wr_en_q   <= 1'b0;
         reg_wr_addr_q <= '0;
         wb_mux_sel_q  <= 1'b0;
      end else begin
         if (stall) begin
            // Bubble: only the write enable is killed, the rest keeps its value.
            reg_wr_en_q <= 1'b0;
         end else begin
            alu_data_q    <= alu_data;
            reg_wr_en_q   <= reg_wr_en;
            reg_wr_addr_q <= reg_wr_addr;
            wb_mux_sel_q  <= wb_mux_sel;
         end
         // Load data has its own strobe so that ALU ops and stores leave it alone.
         if (load_en) begin
            mem_data_q <= load_data;
         end
      end
   end

endmodule

// File: rtl/memory_access.sv
// memory_access
//   MEM stage of the udlx pipeline. Turns loads/stores from EX/MEM into a
//   request/ack data-memory transaction, stalls the upstream pipeline while
//   the access is outstanding, aborts with a one-cycle error pulse after
//   ACK_TIMEOUT access cycles without ack, and feeds the MEM/WB register.
//   Ports:
//     clk, rst_n                          clock, asynchronous active-low reset
//     mem_data_rd_en_in/mem_data_wr_en_in load / store request (store wins if both)
//     mem_data_in                         store data
//     alu_data_in                         ALU result, also the memory address
//     reg_wr_en_in, reg_wr_addr_in, write_back_mux_sel_in
//                                         write-back control from EX/MEM
//     data_mem_req_out, data_mem_we_out   registered request and write strobe
//     data_mem_addr_out, data_mem_wdata_out
//                                         registered address / write data
//     data_mem_rdata_in, data_mem_ack_in  memory read data and acknowledge
//     stall_out                           combinational upstream freeze
//     mem_error_out                       one-cycle pulse on access timeout
//     mem_data_out, alu_data_out, reg_wr_en_out, reg_wr_addr_out,
//     write_back_mux_sel_out              MEM/WB register outputs
module memory_access
   import udlx_pkg::*;
#(
   parameter int DATA_WIDTH     = UDLX_DATA_WIDTH,
   parameter int REG_ADDR_WIDTH = UDLX_REG_ADDR_WIDTH,
   parameter int ACK_TIMEOUT    = UDLX_ACK_TIMEOUT
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      mem_data_rd_en_in,
   input  logic                      mem_data_wr_en_in,
   input  logic [DATA_WIDTH-1:0]     mem_data_in,
   input  logic [DATA_WIDTH-1:0]     alu_data_in,
   input  logic                      reg_wr_en_in,
   input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
   input  logic                      write_back_mux_sel_in,
   output logic                      data_mem_req_out,
   output logic                      data_mem_we_out,
   output logic [DATA_WIDTH-1:0]     data_mem_addr_out,
   output logic [DATA_WIDTH-1:0]     data_mem_wdata_out,
   input  logic [DATA_WIDTH-1:0]     data_mem_rdata_in,
   input  logic                      data_mem_ack_in,
   output logic                      stall_out,
   output logic                      mem_error_out,
   output logic [DATA_WIDTH-1:0]     mem_data_out,
   output logic [DATA_WIDTH-1:0]     alu_data_out,
   output logic                      reg_wr_en_out,
   output logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_out,
   output logic                      write_back_mux_sel_out
);

   // Wide enough to hold ACK_TIMEOUT-1 even for ACK_TIMEOUT = 1.
   localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   mem_state_t            state;
   logic [CNT_W-1:0]      wait_cnt;
   logic                  access;
   logic                  in_access;
   logic                  timeout;
   logic                  load_en;
   logic [DATA_WIDTH-1:0] load_data;

   assign access    = mem_data_rd_en_in | mem_data_wr_en_in;
   assign in_access = (state == ACCESS);
   // Last permitted access cycle passing without ack; an ack in this very
   // cycle still completes the access normally.
   assign timeout   = in_access && !data_mem_ack_in && (wait_cnt == CNT_LAST);

   // The timeout cycle releases the stall so the instruction retires on the
   // same edge that the FSM returns to IDLE.
   assign stall_out = (!in_access && access) ||
                      (in_access && !data_mem_ack_in && !timeout);

   // A timed-out load writes back 0; a store never touches the load data,
   // not even on timeout.
   assign load_en   = in_access && !data_mem_we_out && (data_mem_ack_in || timeout);
   assign load_data = data_mem_ack_in ? data_mem_rdata_in : '0;

   // EX/MEM -> memory request stage boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         wait_cnt           <= '0;
         data_mem_req_out   <= 1'b0;
         data_mem_we_out    <= 1'b0;
         data_mem_addr_out  <= '0;
         data_mem_wdata_out <= '0;
         mem_error_out      <= 1'b0;
      end else begin
         mem_error_out <= 1'b0;
         case (state)
            IDLE: begin
               if (access) begin
                  state              <= ACCESS;
                  wait_cnt           <= '0;
                  data_mem_req_out   <= 1'b1;
                  data_mem_we_out    <= mem_data_wr_en_in;
                  data_mem_addr_out  <= alu_data_in;
                  data_mem_wdata_out <= mem_data_in;
               end
            end
            ACCESS: begin
               if (data_mem_ack_in || timeout) begin
                  state            <= IDLE;
                  wait_cnt         <= '0;
                  data_mem_req_out <= 1'b0;
                  mem_error_out    <= timeout;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            default: begin
               state            <= IDLE;
               data_mem_req_out <= 1'b0;
            end
         endcase
      end
   end

   memory_pipe #(
      .DATA_WIDTH     (DATA_WIDTH),
      .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
   ) u_memory_pipe (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall_out),
      .alu_data      (alu_data_in),
      .reg_wr_en     (reg_wr_en_in),
      .reg_wr_addr   (reg_wr_addr_in),
      .wb_mux_sel    (write_back_mux_sel_in),
      .load_en       (load_en),
      .load_data     (load_data),
      .mem_data_q    (mem_data_out),
      .alu_data_q    (alu_data_out),
      .reg_wr_en_q   (reg_wr_en_out),
      .reg_wr_addr_q (reg_wr_addr_out),
      .wb_mux_sel_q  (write_back_mux_sel_out)
   );

endmodule
